// File: rtl/lp_filter_cascade.sv
// lp_filter_cascade: cascade of up to NSTAGE first-order leaky-integrator
// low-pass stages sharing one time-constant code, with preload, bypass and
// sticky per-stage accumulator saturation flags.
module lp_filter_cascade #(
  parameter int R      = 14,
  parameter int S      = 58,
  parameter int NSTAGE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [5:0]           tau,
  input  logic [3:0]           order,
  input  logic                 init,
  input  logic                 sat_clr,
  input  logic signed [R-1:0]  in,
  output logic signed [R-1:0]  out,
  output logic                 out_valid,
  output logic [NSTAGE-1:0]    sat
);

  localparam logic signed [S-1:0] ACC_MAX  = {1'b0, {(S-1){1'b1}}};
  localparam logic signed [S-1:0] ACC_MIN  = {1'b1, {(S-1){1'b0}}};
  localparam logic signed [S-1:0] Y_MAX    = {{(S-R+1){1'b0}}, {(R-1){1'b1}}};
  localparam logic signed [S-1:0] Y_MIN    = {{(S-R+1){1'b1}}, {(R-1){1'b0}}};
  localparam logic [3:0]          NSTAGE_C = 4'(NSTAGE);

  // The S+1-bit update result overflowed S bits when its top two bits differ
  function automatic logic acc_ovf(input logic signed [S:0] v);
    return v[S] != v[S-1];
  endfunction

  function automatic logic signed [S-1:0] clamp_acc(input logic signed [S:0] v);
    if (acc_ovf(v)) return v[S] ? ACC_MIN : ACC_MAX;
    return $signed(v[S-1:0]);
  endfunction

  function automatic logic signed [R-1:0] sat_y(input logic signed [S-1:0] v);
    if (v > Y_MAX) return Y_MAX[R-1:0];
    if (v < Y_MIN) return Y_MIN[R-1:0];
    return $signed(v[R-1:0]);
  endfunction

  logic [4:0]          sh;
  logic                bypass;
  logic [3:0]          eff;
  logic signed [S-1:0] init_acc;
  logic signed [R-1:0] out_nxt;
  logic [NSTAGE-1:0]   ovf;
  logic [NSTAGE-1:0]   active;
  logic [NSTAGE-1:0]   sat_nxt;
  logic                vld_p1;

  logic signed [R-1:0] x_p0    [NSTAGE];
  logic signed [S-1:0] dec_p0  [NSTAGE];
  logic signed [S:0]   acc_p0  [NSTAGE];
  logic signed [S-1:0] sum_nxt [NSTAGE];
  logic signed [R-1:0] y_nxt   [NSTAGE];
  logic signed [S-1:0] sum_p1  [NSTAGE];
  logic signed [R-1:0] y_p1    [NSTAGE];

  // Stage inputs: stage 0 takes the filter input, later stages the previous registered y
  assign x_p0[0] = in;
  for (genvar k = 1; k < NSTAGE; k++) begin : g_chain
    assign x_p0[k] = y_p1[k-1];
  end

  // Per-stage update, clamping, output selection and sticky-flag next state
  always_comb begin
    sh       = 5'd14 + {1'b0, tau[3:0]};
    bypass   = |tau[5:4];
    eff      = (order > NSTAGE_C) ? NSTAGE_C : order;
    init_acc = $signed({{(S-R){in[R-1]}}, in}) <<< sh;
    out_nxt  = in;
    for (int k = 0; k < NSTAGE; k++) begin
      dec_p0[k]  = sum_p1[k] >>> sh;
      acc_p0[k]  = $signed({sum_p1[k][S-1], sum_p1[k]})
                 + $signed({{(S+1-R){x_p0[k][R-1]}}, x_p0[k]})
                 - $signed({dec_p0[k][S-1], dec_p0[k]});
      sum_nxt[k] = clamp_acc(acc_p0[k]);
      ovf[k]     = acc_ovf(acc_p0[k]);
      y_nxt[k]   = sat_y(sum_nxt[k] >>> sh);
      active[k]  = !bypass && (4'(k) < eff);
      sat_nxt[k] = (sat[k] && !sat_clr) || (ce && !init && active[k] && ovf[k]);
      if (!bypass && (4'(k) + 4'd1 == eff)) out_nxt = y_nxt[k];
    end
  end

  // ---- stage boundary p0 -> p1: accumulators, stage outputs, output register
  // Preload on init, otherwise advance the active stages on ce edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        sum_p1[k] <= '0;
        y_p1[k]   <= '0;
      end
      out    <= '0;
      vld_p1 <= 1'b0;
    end else if (init) begin
      for (int k = 0; k < NSTAGE; k++) begin
        sum_p1[k] <= init_acc;
        y_p1[k]   <= in;
      end
      out    <= in;
      vld_p1 <= 1'b1;
    end else begin
      vld_p1 <= ce;
      if (ce) begin
        for (int k = 0; k < NSTAGE; k++) begin
          if (active[k]) begin
            sum_p1[k] <= sum_nxt[k];
            y_p1[k]   <= y_nxt[k];
          end
        end
        out <= out_nxt;
      end
    end
  end

  // Sticky saturation flags; a clamp on the clearing edge keeps its bit set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat <= '0;
    else      sat <= sat_nxt;
  end

  assign out_valid = vld_p1;

endmodule

// File: tb/tb_lp_filter_cascade.sv
// Bench for lp_filter_cascade: constant vector table, scoreboard against a
// behavioural model, step response, async reset and saturation sequences.
module tb_lp_filter_cascade;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce, init, sat_clr;
  logic [5:0]         tau;
  logic [3:0]         order;
  logic signed [13:0] din;
  logic signed [13:0] out, out32;
  logic               out_valid, vld32;
  logic [3:0]         sat, sat32;

  lp_filter_cascade #(.R(14), .S(58), .NSTAGE(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .tau(tau), .order(order), .init(init),
    .sat_clr(sat_clr), .in(din), .out(out), .out_valid(out_valid), .sat(sat));

  lp_filter_cascade #(.R(14), .S(32), .NSTAGE(4)) dut32 (
    .clk(clk), .rst(rst), .ce(ce), .tau(tau), .order(order), .init(init),
    .sat_clr(sat_clr), .in(din), .out(out32), .out_valid(vld32), .sat(sat32));

  always #4 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model of the default-parameter instance (S=58, NSTAGE=4)
  localparam longint AMAX = (longint'(1) <<< 57) - 1;
  localparam longint AMIN = -(longint'(1) <<< 57);
  longint m_sum [4];
  longint m_y   [4];
  longint m_out;
  longint sb_q [$];

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_sum[k] = 0;
      m_y[k]   = 0;
    end
    m_out = 0;
  endfunction

  function automatic void model_step(input logic c, input logic i, input logic [5:0] t,
                                     input logic [3:0] o, input longint d);
    int     sh, eff;
    longint ns [4];
    longint ny [4];
    longint x, n;
    sh = 14 + int'(t[3:0]);
    if (i) begin
      for (int k = 0; k < 4; k++) begin
        m_sum[k] = d * (longint'(1) <<< sh);
        m_y[k]   = d;
      end
      m_out = d;
      return;
    end
    if (!c) return;
    eff = (o > 4'd4) ? 4 : int'(o);
    if (t[5:4] != 2'b00 || eff == 0) begin
      m_out = d;
      return;
    end
    for (int k = 0; k < eff; k++) begin
      x = (k == 0) ? d : m_y[k-1];
      n = m_sum[k] + x - (m_sum[k] >>> sh);
      if (n > AMAX) n = AMAX;
      if (n < AMIN) n = AMIN;
      ns[k] = n;
      ny[k] = n >>> sh;
      if (ny[k] > 8191)  ny[k] = 8191;
      if (ny[k] < -8192) ny[k] = -8192;
    end
    for (int k = 0; k < eff; k++) begin
      m_sum[k] = ns[k];
      m_y[k]   = ny[k];
    end
    m_out = ny[eff-1];
  endfunction

  // One clock: drive at the falling edge, model at the rising edge, check 1 ns later
  task automatic tick(input logic c, input logic i, input logic sc, input logic signed [13:0] d);
    ce = c; init = i; sat_clr = sc; din = d;
    @(posedge clk);
    model_step(c, i, tau, order, longint'(d));
    if (c || i) sb_q.push_back(m_out);
    #1;
    chk("out_valid", longint'(out_valid), (c || i) ? 1 : 0);
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: out_valid with out=%0d, expected no output", out);
      end else begin
        chk("out", longint'(out), sb_q.pop_front());
      end
    end else begin
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic               c;
    logic               i;
    logic [5:0]         t;
    logic [3:0]         o;
    logic signed [13:0] d;
    logic signed [13:0] eo;
    logic               ev;
  } vec_t;

  vec_t   tbl [13];
  longint prev;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 6'd3,  4'd4, -14'sd2000, -14'sd2000, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 6'd3,  4'd4, -14'sd2000, -14'sd2000, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 6'd3,  4'd4, -14'sd2000, -14'sd2000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 6'd3,  4'd4, -14'sd2000, -14'sd2000, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 6'd16, 4'd4, 14'sd5,     14'sd5,     1'b1};
    tbl[5]  = '{1'b1, 1'b0, 6'd16, 4'd4, 14'sd6,     14'sd6,     1'b1};
    tbl[6]  = '{1'b1, 1'b0, 6'd32, 4'd4, -14'sd7,    -14'sd7,    1'b1};
    tbl[7]  = '{1'b0, 1'b0, 6'd48, 4'd4, 14'sd100,   -14'sd7,    1'b0};
    tbl[8]  = '{1'b1, 1'b0, 6'd3,  4'd4, -14'sd2000, -14'sd2000, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 6'd0,  4'd0, 14'sd123,   14'sd123,   1'b1};
    tbl[10] = '{1'b1, 1'b0, 6'd0,  4'd0, 14'sh2000,  14'sh2000,  1'b1};
    tbl[11] = '{1'b0, 1'b1, 6'd0,  4'd1, 14'sd8191,  14'sd8191,  1'b1};
    tbl[12] = '{1'b1, 1'b0, 6'd0,  4'd1, 14'sd8191,  14'sd8191,  1'b1};

    rst = 1'b0; ce = 1'b0; init = 1'b0; sat_clr = 1'b0;
    tau = '0; order = '0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", longint'(out), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_out32", longint'(out32), 0);
    chk("rst_sat32", longint'(sat32), 0);
    rst = 1'b1;

    // Constant vectors: preload, hold, bypass, order 0
    for (int v = 0; v < 13; v++) begin
      tau = tbl[v].t; order = tbl[v].o;
      tick(tbl[v].c, tbl[v].i, 1'b0, tbl[v].d);
      chk($sformatf("tbl%0d_out", v), longint'(out), longint'(tbl[v].eo));
      chk($sformatf("tbl%0d_vld", v), longint'(out_valid), longint'(tbl[v].ev));
    end

    // Order-2 step with a ce gap, then random data with tau/order changes
    tau = 6'd0; order = 4'd2;
    tick(1'b0, 1'b1, 1'b0, 14'sd0);
    repeat (60) tick(1'b1, 1'b0, 1'b0, 14'sd1000);
    prev = longint'(out);
    tick(1'b0, 1'b0, 1'b0, 14'sd1000);
    chk("freeze1", longint'(out), prev);
    tick(1'b0, 1'b0, 1'b0, 14'sd1000);
    chk("freeze2", longint'(out), prev);
    tick(1'b1, 1'b0, 1'b0, 14'sd1000);
    tau = 6'd2; order = 4'd4;
    repeat (100) tick($urandom_range(0, 3) != 0, 1'b0, 1'b0, 14'($urandom_range(0, 16383)));
    order = 4'd9;
    repeat (50) tick($urandom_range(0, 3) != 0, 1'b0, 1'b0, 14'($urandom_range(0, 16383)));
    tau = 6'd1; order = 4'd3;
    repeat (60) tick($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 1'b0,
                     14'($urandom_range(0, 16383)));
    chk("sat_main_a", longint'(sat), 0);

    // Step response from reset, order 1, tau 0
    rst = 1'b0;
    #1;
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    tau = 6'd0; order = 4'd1;
    prev = 0;
    for (int n = 0; n < 3000; n++) begin
      tick(1'b1, 1'b0, 1'b0, 14'sd1000);
      chk("step_mono", longint'(longint'(out) >= prev), 1);
      chk("step_bound", longint'(longint'(out) <= 1000), 1);
      prev = longint'(out);
    end

    // Reset pulled low between edges, with an init pending
    #1;
    rst = 1'b0; init = 1'b1;
    #1;
    chk("arst_out", longint'(out), 0);
    chk("arst_valid", longint'(out_valid), 0);
    chk("arst_sat", longint'(sat), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_out", longint'(out), 0);
    @(negedge clk);
    rst = 1'b1; init = 1'b0;
    model_reset();
    sb_q.delete();
    tick(1'b0, 1'b0, 1'b0, 14'sd500);
    chk("post_rst_out", longint'(out), 0);

    // Saturation on the S=32 instance
    tau = 6'd15; order = 4'd1;
    tick(1'b0, 1'b1, 1'b0, -14'sd4);
    chk("s32_init_out", longint'(out32), -4);
    chk("s32_init_sat", longint'(sat32), 0);
    tick(1'b1, 1'b0, 1'b0, 14'sh2000);
    chk("s32_clamp_sat", longint'(sat32), 1);
    chk("s32_clamp_out", longint'(out32), -4);
    tick(1'b0, 1'b0, 1'b1, 14'sh2000);
    chk("s32_clr_sat", longint'(sat32), 0);
    tick(1'b1, 1'b0, 1'b1, 14'sh2000);
    chk("s32_clr_vs_clamp", longint'(sat32), 1);
    tick(1'b1, 1'b0, 1'b0, 14'sd0);
    chk("s32_sticky", longint'(sat32), 1);
    tick(1'b0, 1'b0, 1'b1, 14'sd0);
    chk("s32_clr2", longint'(sat32), 0);
    tick(1'b1, 1'b0, 1'b0, 14'sh2000);
    chk("s32_reclamp", longint'(sat32), 1);
    chk("sat_main_d", longint'(sat), 0);

    // Async reset also clears sticky flags
    #1;
    rst = 1'b0;
    #1;
    chk("arst_sat32", longint'(sat32), 0);
    chk("arst_out32", longint'(out32), 0);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
